// File: rtl/not_not_judge.sv
// Player-side judge for the Not-Not game: requests challenges, captures answers, keeps score and lives.
// Optional feature: define NOT_NOT_SPEEDUP_EN to shorten the round by one second every 4th correct answer.
module not_not_judge #(
   parameter int CLK_HZ        = 50000000,
   parameter int ROUND_SECONDS = 5,
   parameter int START_LIVES   = 3,
   parameter int SHOW_CYCLES   = 25000000,
   parameter int SCORE_W       = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               submit,
   input  logic [3:0]         answer_sw,
   input  logic [3:0]         expected_mask,
   output logic               new_challenge,
   output logic               round_active,
   output logic [3:0]         time_left,
   output logic               result_valid,
   output logic               result_correct,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         lives,
   output logic               game_over
);

   localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int SHOW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_HZ - 1);
   localparam logic [SHOW_W-1:0]  SHOW_MAX   = SHOW_W'(SHOW_CYCLES - 1);
   localparam logic [3:0]         ROUND_LEN  = 4'(ROUND_SECONDS);
   localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_LATCH = 3'd2,
      S_WAIT  = 3'd3,
      S_JUDGE = 3'd4,
      S_SHOW  = 3'd5,
      S_OVER  = 3'd6
   } state_t;

   state_t               state_r, state_s;
   logic [PRESC_W-1:0]   presc_r, presc_s;
   logic [SHOW_W-1:0]    show_cnt_r, show_cnt_s;
   logic [3:0]           time_left_r, time_left_s;
   logic [3:0]           exp_r, exp_s;
   logic [3:0]           ans_r, ans_s;
   logic                 correct_r, correct_s;
   logic [SCORE_W-1:0]   score_r, score_s;
   logic [1:0]           lives_r, lives_s;
`ifdef NOT_NOT_SPEEDUP_EN
   logic [3:0]           round_len_r, round_len_s;
`endif

   logic                 start_s1_r, start_s2_r, start_prev_r;
   logic                 submit_s1_r, submit_s2_r, submit_prev_r;
   logic [3:0]           ans_s1_r, ans_s2_r;
   logic                 start_edge_s, submit_edge_s;

   assign start_edge_s  = start_s2_r & ~start_prev_r;
   assign submit_edge_s = submit_s2_r & ~submit_prev_r;

   // Next-state and datapath updates for the game sequence
   always_comb begin
      state_s     = state_r;
      presc_s     = presc_r;
      show_cnt_s  = show_cnt_r;
      time_left_s = time_left_r;
      exp_s       = exp_r;
      ans_s       = ans_r;
      correct_s   = correct_r;
      score_s     = score_r;
      lives_s     = lives_r;
`ifdef NOT_NOT_SPEEDUP_EN
      round_len_s = round_len_r;
`endif
      case (state_r)
         S_IDLE, S_OVER: begin
            if (start_edge_s) begin
               state_s = S_LOAD;
               score_s = {SCORE_W{1'b0}};
               lives_s = LIVES_INIT;
`ifdef NOT_NOT_SPEEDUP_EN
               round_len_s = ROUND_LEN;
`endif
            end else begin
               state_s = state_r;
            end
         end
         S_LOAD: state_s = S_LATCH;
         S_LATCH: begin
            exp_s   = expected_mask;
`ifdef NOT_NOT_SPEEDUP_EN
            time_left_s = round_len_r;
`else
            time_left_s = ROUND_LEN;
`endif
            presc_s = {PRESC_W{1'b0}};
            state_s = S_WAIT;
         end
         S_WAIT: begin
            // A submit edge takes priority over a simultaneous timeout
            if (submit_edge_s) begin
               ans_s   = ans_s2_r;
               state_s = S_JUDGE;
            end else if (presc_r == PRESC_MAX) begin
               presc_s = {PRESC_W{1'b0}};
               if (time_left_r == 4'd1) begin
                  time_left_s = 4'd0;
                  ans_s       = 4'b0000;
                  state_s     = S_JUDGE;
               end else begin
                  time_left_s = time_left_r - 4'd1;
               end
            end else begin
               presc_s = presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
         end
         S_JUDGE: begin
            if (correct_r) begin
               if (score_r != SCORE_MAX) begin
                  score_s = score_r + SCORE_ONE;
`ifdef NOT_NOT_SPEEDUP_EN
                  if ((score_s[1:0] == 2'b00) && (round_len_r > 4'd1)) begin
                     round_len_s = round_len_r - 4'd1;
                  end else begin
                     round_len_s = round_len_r;
                  end
`endif
               end else begin
                  score_s = score_r;
               end
            end else begin
               lives_s = lives_r - 2'd1;
            end
            show_cnt_s = {SHOW_W{1'b0}};
            state_s    = S_SHOW;
         end
         S_SHOW: begin
            if (show_cnt_r == SHOW_MAX) begin
               state_s = (lives_r == 2'd0) ? S_OVER : S_LOAD;
            end else begin
               show_cnt_s = show_cnt_r + {{(SHOW_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_s = S_IDLE;
      endcase

      if ((state_r == S_WAIT) && (state_s == S_JUDGE)) begin
         correct_s = (ans_s == exp_r);
      end else if (state_s == S_LOAD) begin
         correct_s = 1'b0;
      end else begin
         correct_s = correct_r;
      end
   end

   // State, datapath, synchronizers and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r        <= S_IDLE;
         presc_r        <= {PRESC_W{1'b0}};
         show_cnt_r     <= {SHOW_W{1'b0}};
         time_left_r    <= 4'd0;
         exp_r          <= 4'd0;
         ans_r          <= 4'd0;
         correct_r      <= 1'b0;
         score_r        <= {SCORE_W{1'b0}};
         lives_r        <= LIVES_INIT;
`ifdef NOT_NOT_SPEEDUP_EN
         round_len_r    <= ROUND_LEN;
`endif
         start_s1_r     <= 1'b1;
         start_s2_r     <= 1'b1;
         start_prev_r   <= 1'b1;
         submit_s1_r    <= 1'b1;
         submit_s2_r    <= 1'b1;
         submit_prev_r  <= 1'b1;
         ans_s1_r       <= 4'b1111;
         ans_s2_r       <= 4'b1111;
         new_challenge  <= 1'b0;
         round_active   <= 1'b0;
         result_valid   <= 1'b0;
         game_over      <= 1'b0;
      end else begin
         state_r        <= state_s;
         presc_r        <= presc_s;
         show_cnt_r     <= show_cnt_s;
         time_left_r    <= time_left_s;
         exp_r          <= exp_s;
         ans_r          <= ans_s;
         correct_r      <= correct_s;
         score_r        <= score_s;
         lives_r        <= lives_s;
`ifdef NOT_NOT_SPEEDUP_EN
         round_len_r    <= round_len_s;
`endif
         start_s1_r     <= start;
         start_s2_r     <= start_s1_r;
         start_prev_r   <= start_s2_r;
         submit_s1_r    <= submit;
         submit_s2_r    <= submit_s1_r;
         submit_prev_r  <= submit_s2_r;
         ans_s1_r       <= answer_sw;
         ans_s2_r       <= ans_s1_r;
         new_challenge  <= (state_s == S_LOAD);
         round_active   <= (state_s == S_WAIT);
         result_valid   <= (state_s == S_JUDGE);
         game_over      <= (state_s == S_OVER);
      end
   end

   assign time_left      = time_left_r;
   assign result_correct = correct_r;
   assign score          = score_r;
   assign lives          = lives_r;

endmodule

// File: tb/tb_not_not_judge.sv
// Directed self-checking bench for not_not_judge with a shortened clock/round configuration.
module tb_not_not_judge;

   localparam int CLK_HZ        = 8;
   localparam int ROUND_SECONDS = 2;
   localparam int START_LIVES   = 2;
   localparam int SHOW_CYCLES   = 4;
   localparam int SCORE_W       = 8;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic               submit = 1'b0;
   logic [3:0]         answer_sw = 4'd0;
   logic [3:0]         expected_mask = 4'd0;
   logic               new_challenge, round_active, result_valid, result_correct, game_over;
   logic [3:0]         time_left;
   logic [SCORE_W-1:0] score;
   logic [1:0]         lives;

   int checks = 0;
   int errors = 0;

   not_not_judge #(
      .CLK_HZ(CLK_HZ), .ROUND_SECONDS(ROUND_SECONDS), .START_LIVES(START_LIVES),
      .SHOW_CYCLES(SHOW_CYCLES), .SCORE_W(SCORE_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .submit(submit),
      .answer_sw(answer_sw), .expected_mask(expected_mask),
      .new_challenge(new_challenge), .round_active(round_active), .time_left(time_left),
      .result_valid(result_valid), .result_correct(result_correct), .score(score),
      .lives(lives), .game_over(game_over)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // which: 0 new_challenge, 1 round_active, 2 result_valid, other game_over
   task automatic wait_for(input int which, input int max_cycles, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         tick(1);
         case (which)
            0: seen = new_challenge;
            1: seen = round_active;
            2: seen = result_valid;
            default: seen = game_over;
         endcase
      end
   endtask

   task automatic test_reset;
      bit seen;
      start = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({new_challenge, round_active, time_left, result_valid, result_correct, score, lives, game_over}
          !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h",
                  {new_challenge, round_active, time_left, result_valid, result_correct, score, lives, game_over},
                  {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 2'd2, 1'b0});
      end
      tick(2);
      reset = 1'b0;
      wait_for(0, 8, seen);
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL start_held_through_reset: got pulse %0d expected 0", seen);
      end
      start = 1'b0;
      tick(3);
   endtask

   task automatic test_correct;
      bit seen;
      expected_mask = 4'b0101;
      answer_sw     = 4'b0101;
      start = 1'b1;
      wait_for(0, 10, seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL start_challenge: got %0d expected 1", seen); end
      start = 1'b0;
      tick(1);
      checks++;
      if (new_challenge !== 1'b0) begin errors++; $display("FAIL one_pulse: got %0d expected 0", new_challenge); end
      tick(1);
      checks++;
      if ({round_active, time_left, new_challenge} !== {1'b1, 4'd2, 1'b0}) begin
         errors++; $display("FAIL wait_entry: got %h expected %h", {round_active, time_left, new_challenge}, {1'b1, 4'd2, 1'b0});
      end
      submit = 1'b1;
      tick(2);
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %0d expected 0", result_valid); end
      tick(1);
      checks++;
      if ({result_valid, result_correct} !== 2'b11) begin
         errors++; $display("FAIL judge_correct: got %b expected 11", {result_valid, result_correct});
      end
      submit = 1'b0;
      tick(1);
      checks++;
      if ({result_valid, result_correct, score, lives} !== {1'b0, 1'b1, 8'd1, 2'd2}) begin
         errors++; $display("FAIL score_after_correct: got %h expected %h", {result_valid, result_correct, score, lives}, {1'b0, 1'b1, 8'd1, 2'd2});
      end
      tick(3);
      checks++;
      if (new_challenge !== 1'b0) begin errors++; $display("FAIL show_early_load: got %0d expected 0", new_challenge); end
      tick(1);
      checks++;
      if (new_challenge !== 1'b1) begin errors++; $display("FAIL next_challenge_5: got %0d expected 1", new_challenge); end
   endtask

   task automatic test_timeout;
      expected_mask = 4'b0000;
      tick(2);
      checks++;
      if ({round_active, time_left} !== {1'b1, 4'd2}) begin
         errors++; $display("FAIL timeout_entry: got %h expected %h", {round_active, time_left}, {1'b1, 4'd2});
      end
      tick(7);
      checks++;
      if (time_left !== 4'd2) begin errors++; $display("FAIL tl_before_wrap1: got %0d expected 2", time_left); end
      tick(1);
      checks++;
      if (time_left !== 4'd1) begin errors++; $display("FAIL tl_after_wrap1: got %0d expected 1", time_left); end
      tick(7);
      checks++;
      if ({time_left, result_valid} !== {4'd1, 1'b0}) begin
         errors++; $display("FAIL tl_before_wrap2: got %h expected %h", {time_left, result_valid}, {4'd1, 1'b0});
      end
      tick(1);
      checks++;
      if ({time_left, result_valid, result_correct, round_active} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL timeout_judge: got %h expected %h", {time_left, result_valid, result_correct, round_active}, {4'd0, 1'b1, 1'b1, 1'b0});
      end
      tick(1);
      checks++;
      if (score !== 8'd2) begin errors++; $display("FAIL timeout_score: got %0d expected 2", score); end
      tick(4);
      checks++;
      if ({new_challenge, result_correct, time_left} !== {1'b1, 1'b0, 4'd0}) begin
         errors++; $display("FAIL load_clears_correct: got %h expected %h", {new_challenge, result_correct, time_left}, {1'b1, 1'b0, 4'd0});
      end
   endtask

   task automatic test_lives_game_over;
      bit seen;
      bit rv;
      expected_mask = 4'b1000;
      answer_sw     = 4'b0001;
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            wait_for(0, 10, seen);
            checks++;
            if (seen !== 1'b1) begin errors++; $display("FAIL wrong_round2_start: got %0d expected 1", seen); end
         end
         tick(2);
         submit = 1'b1;
         tick(3);
         checks++;
         if ({result_valid, result_correct} !== 2'b10) begin
            errors++; $display("FAIL judge_wrong%0d: got %b expected 10", r, {result_valid, result_correct});
         end
         submit = 1'b0;
         tick(1);
         checks++;
         if ({lives, score} !== {2'(1 - r), 8'd2}) begin
            errors++; $display("FAIL lives_dec%0d: got %h expected %h", r, {lives, score}, {2'(1 - r), 8'd2});
         end
      end
      tick(3);
      checks++;
      if (game_over !== 1'b0) begin errors++; $display("FAIL over_early: got %0d expected 0", game_over); end
      tick(1);
      checks++;
      if ({game_over, round_active, new_challenge} !== 3'b100) begin
         errors++; $display("FAIL game_over: got %b expected 100", {game_over, round_active, new_challenge});
      end
      rv = 1'b0;
      for (int k = 0; k < 3; k++) begin
         submit = 1'b1;
         for (int c = 0; c < 4; c++) begin tick(1); rv |= result_valid | new_challenge; end
         submit = 1'b0;
         for (int c = 0; c < 2; c++) begin tick(1); rv |= result_valid | new_challenge; end
      end
      checks++;
      if ({rv, score, lives, game_over} !== {1'b0, 8'd2, 2'd0, 1'b1}) begin
         errors++; $display("FAIL over_ignores_submit: got %h expected %h", {rv, score, lives, game_over}, {1'b0, 8'd2, 2'd0, 1'b1});
      end
      start = 1'b1;
      wait_for(0, 10, seen);
      checks++;
      if ({seen, lives, score, game_over} !== {1'b1, 2'd2, 8'd0, 1'b0}) begin
         errors++; $display("FAIL restart: got %h expected %h", {seen, lives, score, game_over}, {1'b1, 2'd2, 8'd0, 1'b0});
      end
      start = 1'b0;
   endtask

   task automatic test_submit_at_wrap;
      expected_mask = 4'b0110;
      answer_sw     = 4'b0110;
      tick(2);
      tick(13);
      submit = 1'b1;
      tick(1);
      checks++;
      if ({round_active, result_valid} !== 2'b10) begin
         errors++; $display("FAIL wrap_c15: got %b expected 10", {round_active, result_valid});
      end
      tick(1);
      checks++;
      if ({round_active, time_left} !== {1'b1, 4'd1}) begin
         errors++; $display("FAIL wrap_c16: got %h expected %h", {round_active, time_left}, {1'b1, 4'd1});
      end
      tick(1);
      checks++;
      if ({result_valid, result_correct} !== 2'b11) begin
         errors++; $display("FAIL submit_beats_timeout: got %b expected 11", {result_valid, result_correct});
      end
      submit = 1'b0;
      tick(1);
      checks++;
      if (score !== 8'd1) begin errors++; $display("FAIL wrap_score: got %0d expected 1", score); end
   endtask

   task automatic test_reset_mid_wait;
      bit seen;
      wait_for(0, 10, seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL midwait_round: got %0d expected 1", seen); end
      tick(5);
      reset = 1'b1;
      #1;
      checks++;
      if ({new_challenge, round_active, time_left, result_valid, result_correct, score, lives, game_over}
          !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL midwait_reset: got %h expected %h",
                  {new_challenge, round_active, time_left, result_valid, result_correct, score, lives, game_over},
                  {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 2'd2, 1'b0});
      end
      tick(2);
      reset = 1'b0;
      wait_for(0, 6, seen);
      checks++;
      if ({seen, round_active, lives} !== {1'b0, 1'b0, 2'd2}) begin
         errors++; $display("FAIL idle_after_reset: got %h expected %h", {seen, round_active, lives}, {1'b0, 1'b0, 2'd2});
      end
   endtask

`ifdef NOT_NOT_SPEEDUP_EN
   task automatic test_speedup;
      bit seen;
      expected_mask = 4'b0011;
      answer_sw     = 4'b0011;
      start = 1'b1;
      wait_for(0, 10, seen);
      start = 1'b0;
      for (int r = 0; r < 9; r++) begin
         tick(2);
         checks++;
         if (time_left !== ((r < 4) ? 4'd2 : 4'd1)) begin
            errors++; $display("FAIL speedup_round%0d: got %0d expected %0d", r, time_left, (r < 4) ? 2 : 1);
         end
         submit = 1'b1;
         tick(3);
         submit = 1'b0;
         wait_for(0, 10, seen);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_correct;
      test_timeout;
      test_lives_game_over;
      test_submit_at_wrap;
      test_reset_mid_wait;
`ifdef NOT_NOT_SPEEDUP_EN
      test_speedup;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/not_not_judge.md
Name: not_not_judge

Overview:
- Player-side counterpart to the Not-Not challenge generator.
- The generator produces an expected 4-bit answer mask. This block requests each new challenge, captures the player's switch answer on a key press or on timeout, and judges it.
- Keeps score and lives, and drives round and game-over status to the HEX/LED display logic.
- Sits between board inputs (SW/KEY, already inverted to active-high) and the generator's LFSR enable.

Parameters:
- CLK_HZ, 50000000, clock cycles per one-second tick.
- ROUND_SECONDS, 5, seconds allowed per round; range 1..15.
- START_LIVES, 3, lives at game start; range 1..3.
- SHOW_CYCLES, 25000000, cycles the result is held before the next round.
- SCORE_W, 8, score width.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- start  in  1  start/restart request, level input
- submit  in  1  answer submit key, level input
- answer_sw  in  4  player's colour switch answer
- expected_mask  in  4  generator's expected answer
- new_challenge  out  1  one-cycle pulse; enables generator LFSRs
- round_active  out  1  high while waiting for an answer
- time_left  out  4  seconds remaining in the current round
- result_valid  out  1  one-cycle pulse when an answer is judged
- result_correct  out  1  verdict; held through SHOW
- score  out  SCORE_W  correct-answer count
- lives  out  2  remaining lives
- game_over  out  1  high in OVER

Behaviour:
- Reset (async, active-high):
  - state IDLE; score 0; lives START_LIVES; time_left 0.
  - new_challenge, round_active, result_valid, result_correct and game_over all 0.
  - Synchronizers and edge-detect registers reset to 1, so an input held high through reset produces no edge.
- Inputs:
  - start, submit and answer_sw each pass through a 2-flop synchronizer.
  - Rising edge = s2 & ~prev.
  - result_valid is high in the cycle beginning 3 rising clock edges after submit is first sampled high.
- IDLE: start edge → LOAD; score 0; lives START_LIVES.
- LOAD: new_challenge = 1 for exactly this one cycle → LATCH.
- LATCH:
  - Capture expected_mask into exp_r; the generator output has settled by now.
  - time_left = ROUND_SECONDS; prescaler 0 → WAIT.
- WAIT:
  - round_active = 1.
  - Prescaler counts 0..CLK_HZ-1; on wrap, time_left decrements.
  - Submit edge → capture synchronized answer_sw into ans_r → JUDGE.
  - Wrap with time_left == 1 → time_left 0; ans_r = 4'b0000 (timeout means "answered nothing") → JUDGE.
  - Submit edge and timeout wrap in the same cycle: submit wins.
- JUDGE (1 cycle):
  - result_valid = 1; result_correct = (ans_r == exp_r).
  - Correct: score+1, saturating at 2^SCORE_W-1.
  - Wrong: lives-1 → SHOW.
- SHOW:
  - Counter runs SHOW_CYCLES cycles; result_correct held.
  - Then lives == 0 → OVER, else → LOAD.
- OVER:
  - game_over = 1; score and lives frozen.
  - Start edge → LOAD; score 0; lives START_LIVES.
- Edge handling:
  - Submit edges outside WAIT are ignored.
  - Start edges outside IDLE/OVER are ignored.
- result_correct clears on entry to LOAD.
- time_left holds its last value outside WAIT.
- Reset mid-round aborts immediately to IDLE; no new_challenge pulse.

Optional Feature:
- Macro: NOT_NOT_SPEEDUP_EN.
- Defined:
  - Round length register starts at ROUND_SECONDS.
  - Every 4th correct answer (score[1:0] becomes 0 after increment) decrements it by 1, floor 1.
  - LATCH loads time_left from this register.
  - Register restores to ROUND_SECONDS at game start.
- Undefined: every round is ROUND_SECONDS; no extra registers.

Test Plan:
(CLK_HZ=8, ROUND_SECONDS=2, SHOW_CYCLES=4, START_LIVES=2)
- Reset asserted asynchronously mid-WAIT → same-cycle IDLE; all outputs at reset values; lives=2; no new_challenge.
- Start pulse; expected_mask=4'b0101; answer_sw=4'b0101; submit → exactly one new_challenge pulse; result_valid 3 cycles after submit; result_correct=1; score=1; lives=2; new_challenge again 5 cycles after result_valid.
- expected_mask=4'b0000; no submit → time_left 2→1 after 8 WAIT cycles, 1→0 after 16; result_valid; result_correct=1 (timeout answer matches 0).
- Two wrong answers (expected=4'b1000, answer=4'b0001) → lives 2→1→0; game_over=1 after second SHOW; later submits ignored; score unchanged; start edge → lives=2, score=0, new_challenge pulse.
- submit rising edge in the same cycle as the final prescaler wrap → judged with answer_sw value, not 4'b0000.
- With NOT_NOT_SPEEDUP_EN and ROUND_SECONDS=2: after 4 correct answers the next round's time_left loads 1; after 8 correct answers it stays 1.
